fw_sprite_index_gen: RTL and testbench

- Upstream stage of the game palette lookup. For each VGA pixel, it decides whether Fireboy and/or Watergirl cover that pixel.
- It generates animated, direction-mirrored sprite ROM addresses and reads the synchronous ROM data.
- Transparency is keyed out here.
- Outputs are two pipelined 5-bit palette indices (fireboy, watergirl) plus hit flags, which feed the palette's two index inputs directly.

---
 rtl/fw_sprite_index_gen.sv | 196 +++++++++++++++++++
 tb/tb_fw_sprite_index_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fw_sprite_index_gen.sv
`default_nettype none
// ============================================================================
// fw_sprite_index_gen : animated, mirrored sprite ROM addressing and
//                       transparency keying for Fireboy and Watergirl
// Revision: 1.0
// ============================================================================
module fw_sprite_index_gen #(
   parameter int SPR_W      = 32,
   parameter int SPR_H      = 32,
   parameter int FRAMES     = 4,
   parameter int ANIM_DIV   = 8,
   parameter int TRANSP_IDX = 0,
   parameter int ADDR_W     = 12
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic              vsync,
   input  logic [9:0]        fb_x,
   input  logic [9:0]        fb_y,
   input  logic [9:0]        wg_x,
   input  logic [9:0]        wg_y,
   input  logic              fb_left,
   input  logic              wg_left,
   input  logic              fb_moving,
   input  logic              wg_moving,
   output logic [ADDR_W-1:0] fb_rom_addr,
   output logic [ADDR_W-1:0] wg_rom_addr,
   input  logic [4:0]        fb_rom_q,
   input  logic [4:0]        wg_rom_q,
   output logic [4:0]        index,
   output logic [4:0]        index2,
   output logic              fb_hit,
   output logic              wg_hit,
   output logic              blank_d
);

   localparam int FR_W  = (FRAMES > 2) ? $clog2(FRAMES) : 1;
   localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam logic [FR_W-1:0]  c_frame_last = FR_W'(FRAMES - 1);
   localparam logic [DIV_W-1:0] c_div_last   = DIV_W'(ANIM_DIV - 1);
   localparam logic [4:0]       c_transp     = 5'(TRANSP_IDX);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WALK = 1'b1
   } anim_state_t;

   logic       vsync_q, vsync_d;
   logic       bl1_q, bl1_d, bl2_q, bl2_d, bl3_q, bl3_d;
   logic       tick;

   logic [9:0]        pos_x   [2];
   logic [9:0]        pos_y   [2];
   logic              face_l  [2];
   logic              moving  [2];
   logic [4:0]        rom_q   [2];
   logic [ADDR_W-1:0] addr_o  [2];
   logic [4:0]        idx_o   [2];
   logic              hit_o   [2];

   assign pos_x[0]  = fb_x;      assign pos_x[1]  = wg_x;
   assign pos_y[0]  = fb_y;      assign pos_y[1]  = wg_y;
   assign face_l[0] = fb_left;   assign face_l[1] = wg_left;
   assign moving[0] = fb_moving; assign moving[1] = wg_moving;
   assign rom_q[0]  = fb_rom_q;  assign rom_q[1]  = wg_rom_q;

   // Falling edge of vsync: animation state only moves here, never mid-frame.
   assign tick = vsync_q & ~vsync;

   always_comb begin
      vsync_d = vsync;
      bl1_d   = blank;
      bl2_d   = bl1_q;
      bl3_d   = bl2_q;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         vsync_q <= 1'b1;
         bl1_q   <= 1'b0;
         bl2_q   <= 1'b0;
         bl3_q   <= 1'b0;
      end else begin
         vsync_q <= vsync_d;
         bl1_q   <= bl1_d;
         bl2_q   <= bl2_d;
         bl3_q   <= bl3_d;
      end
   end

   for (genvar c = 0; c < 2; c++) begin : g_chr
      anim_state_t       st_q, st_d;
      logic [FR_W-1:0]   frame_q, frame_d;
      logic [DIV_W-1:0]  div_q, div_d;
      logic [10:0]       dx, dy, col;
      logic              in_box;
      logic [ADDR_W-1:0] addr_q, addr_d;
      logic              in1_q, in1_d, in2_q, in2_d, hit_q, hit_d;
      logic [4:0]        idx_q, idx_d;

      always_comb begin
         st_d    = st_q;
         frame_d = frame_q;
         div_d   = div_q;
         if (tick) begin
            case (st_q)
               ST_IDLE: begin
                  if (moving[c]) begin
                     st_d    = ST_WALK;
                     frame_d = FR_W'(1);
                     div_d   = '0;
                  end
               end
               ST_WALK: begin
                  if (!moving[c]) begin
                     st_d    = ST_IDLE;
                     frame_d = '0;
                     div_d   = '0;
                  end else if (div_q == c_div_last) begin
                     div_d   = '0;
                     frame_d = (frame_q == c_frame_last) ? FR_W'(1) : frame_q + FR_W'(1);
                  end else begin
                     div_d   = div_q + DIV_W'(1);
                  end
               end
               default: begin
                  st_d    = ST_IDLE;
                  frame_d = '0;
                  div_d   = '0;
               end
            endcase
         end
      end

      // 11-bit compares keep boxes near column 1023 from wrapping to 0.
      always_comb begin
         dx     = {1'b0, DrawX} - {1'b0, pos_x[c]};
         dy     = {1'b0, DrawY} - {1'b0, pos_y[c]};
         col    = face_l[c] ? (11'(SPR_W - 1) - dx) : dx;
         in_box = blank
                & ({1'b0, DrawX} >= {1'b0, pos_x[c]})
                & ({1'b0, DrawX} <  ({1'b0, pos_x[c]} + 11'(SPR_W)))
                & ({1'b0, DrawY} >= {1'b0, pos_y[c]})
                & ({1'b0, DrawY} <  ({1'b0, pos_y[c]} + 11'(SPR_H)));
         addr_d = '0;
         if (in_box) begin
            addr_d = ADDR_W'(frame_q) * ADDR_W'(SPR_W * SPR_H)
                   + ADDR_W'(dy) * ADDR_W'(SPR_W)
                   + ADDR_W'(col);
         end
         in1_d = in_box;
         in2_d = in1_q;
         hit_d = in2_q & (rom_q[c] != c_transp);
         idx_d = hit_d ? rom_q[c] : 5'd0;
      end

      always_ff @(posedge Clk) begin
         if (Reset) begin
            st_q    <= ST_IDLE;
            frame_q <= '0;
            div_q   <= '0;
            addr_q  <= '0;
            in1_q   <= 1'b0;
            in2_q   <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
         end else begin
            st_q    <= st_d;
            frame_q <= frame_d;
            div_q   <= div_d;
            addr_q  <= addr_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
         end
      end

      assign addr_o[c] = addr_q;
      assign idx_o[c]  = idx_q;
      assign hit_o[c]  = hit_q;
   end

   assign fb_rom_addr = addr_o[0];
   assign wg_rom_addr = addr_o[1];
   assign index       = idx_o[0];
   assign index2      = idx_o[1];
   assign fb_hit      = hit_o[0];
   assign wg_hit      = hit_o[1];
   assign blank_d     = bl3_q;

endmodule
`default_nettype wire

// File: tb/tb_fw_sprite_index_gen.sv
`default_nettype none
// ============================================================================
// tb_fw_sprite_index_gen : directed + randomized check against a frame-level
//                          reference model of sprite addressing and keying
// Revision: 1.0
// ============================================================================
module tb_fw_sprite_index_gen;

   localparam int SPR_W      = 32;
   localparam int SPR_H      = 32;
   localparam int FRAMES     = 4;
   localparam int ANIM_DIV   = 8;
   localparam int TRANSP_IDX = 0;
   localparam int ADDR_W     = 12;
   localparam int MEM_N      = 1 << ADDR_W;

   logic              Clk = 1'b0;
   logic              Reset;
   logic [9:0]        DrawX, DrawY;
   logic              blank, vsync;
   logic [9:0]        fb_x, fb_y, wg_x, wg_y;
   logic              fb_left, wg_left, fb_moving, wg_moving;
   logic [ADDR_W-1:0] fb_rom_addr, wg_rom_addr;
   logic [4:0]        fb_rom_q, wg_rom_q;
   logic [4:0]        index, index2;
   logic              fb_hit, wg_hit, blank_d;

   fw_sprite_index_gen #(
      .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES), .ANIM_DIV(ANIM_DIV),
      .TRANSP_IDX(TRANSP_IDX), .ADDR_W(ADDR_W)
   ) dut (
      .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
      .blank(blank), .vsync(vsync),
      .fb_x(fb_x), .fb_y(fb_y), .wg_x(wg_x), .wg_y(wg_y),
      .fb_left(fb_left), .wg_left(wg_left),
      .fb_moving(fb_moving), .wg_moving(wg_moving),
      .fb_rom_addr(fb_rom_addr), .wg_rom_addr(wg_rom_addr),
      .fb_rom_q(fb_rom_q), .wg_rom_q(wg_rom_q),
      .index(index), .index2(index2),
      .fb_hit(fb_hit), .wg_hit(wg_hit), .blank_d(blank_d)
   );

   always #5 Clk = ~Clk;

   // Synchronous sprite ROMs owned by the bench.
   logic [4:0] fb_mem [MEM_N];
   logic [4:0] wg_mem [MEM_N];
   always @(posedge Clk) begin
      fb_rom_q <= fb_mem[fb_rom_addr];
      wg_rom_q <= wg_mem[wg_rom_addr];
   end

   int tests = 0;
   int fails = 0;

   // Per-pixel record: what was sampled, and the ROM word that address returns.
   typedef struct {
      bit fi; bit wi; int fa; int wa; int fd; int wd; bit bl;
   } rec_t;
   rec_t q[$];

   bit m_walk [2];
   int m_wt   [2];
   bit m_vs;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int model_frame(input int c);
      return m_walk[c] ? 1 + ((m_wt[c] / ANIM_DIV) % (FRAMES - 1)) : 0;
   endfunction

   function automatic void pix(input int px, input int py, input bit lft, input int fr,
                               output bit inb, output int addr);
      int dx, dy, col, row;
      dx  = int'(DrawX);
      dy  = int'(DrawY);
      inb = (blank === 1'b1) && dx >= px && dx < px + SPR_W && dy >= py && dy < py + SPR_H;
      col = dx - px;
      row = dy - py;
      if (lft) col = SPR_W - 1 - col;
      addr = inb ? fr * SPR_W * SPR_H + row * SPR_W + col : 0;
   endfunction

   // One clock: model the sampled pixel, advance animation on a tick, check outputs.
   task automatic run_cycle();
      rec_t r, t;
      bit   mv;
      r = '{fi: 1'b0, wi: 1'b0, fa: 0, wa: 0, fd: 0, wd: 0, bl: 1'b0};
      pix(int'(fb_x), int'(fb_y), fb_left, model_frame(0), r.fi, r.fa);
      pix(int'(wg_x), int'(wg_y), wg_left, model_frame(1), r.wi, r.wa);
      r.bl = (blank === 1'b1);
      @(posedge Clk);
      t = q[q.size() - 1];
      t.fd = int'(fb_mem[t.fa]);
      t.wd = int'(wg_mem[t.wa]);
      q[q.size() - 1] = t;
      if (Reset) begin
         for (int i = 0; i < q.size(); i++) begin
            t = q[i]; t.fi = 1'b0; t.wi = 1'b0; t.bl = 1'b0; q[i] = t;
         end
         r = '{fi: 1'b0, wi: 1'b0, fa: 0, wa: 0, fd: 0, wd: 0, bl: 1'b0};
         m_walk[0] = 1'b0; m_walk[1] = 1'b0;
         m_wt[0] = 0; m_wt[1] = 0;
         m_vs = 1'b1;
      end else begin
         if (m_vs && !vsync) begin
            for (int c = 0; c < 2; c++) begin
               mv = (c == 0) ? fb_moving : wg_moving;
               if (!mv)              m_walk[c] = 1'b0;
               else if (!m_walk[c]) begin m_walk[c] = 1'b1; m_wt[c] = 0; end
               else                  m_wt[c]++;
            end
         end
         m_vs = vsync;
      end
      q.push_back(r);
      while (q.size() > 3) void'(q.pop_front());
      @(negedge Clk);
      t = q[0];
      chk("fb_rom_addr", 32'(fb_rom_addr), 32'(q[2].fa));
      chk("wg_rom_addr", 32'(wg_rom_addr), 32'(q[2].wa));
      chk("fb_hit", 32'(fb_hit), 32'(t.fi && t.fd != TRANSP_IDX));
      chk("wg_hit", 32'(wg_hit), 32'(t.wi && t.wd != TRANSP_IDX));
      chk("index",  32'(index),  32'((t.fi && t.fd != TRANSP_IDX) ? t.fd : 0));
      chk("index2", 32'(index2), 32'((t.wi && t.wd != TRANSP_IDX) ? t.wd : 0));
      chk("blank_d", 32'(blank_d), 32'(t.bl));
   endtask

   task automatic tick_pulse();
      vsync = 1'b0;
      run_cycle();
      vsync = 1'b1;
      run_cycle();
   endtask

   int exp_frame [5] = '{1, 2, 3, 1, 2};
   int tick_at   [5] = '{1, 9, 17, 25, 33};
   int k;
   int base;

   initial begin
      for (int i = 0; i < MEM_N; i++) begin
         fb_mem[i] = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         wg_mem[i] = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      end
      fb_mem[69]  = 5'd9;
      fb_mem[90]  = 5'd0;
      wg_mem[325] = 5'd17;
      fb_mem[335] = 5'd12;
      wg_mem[165] = 5'd21;

      q.push_back('{fi: 1'b0, wi: 1'b0, fa: 0, wa: 0, fd: 0, wd: 0, bl: 1'b0});
      q.push_back('{fi: 1'b0, wi: 1'b0, fa: 0, wa: 0, fd: 0, wd: 0, bl: 1'b0});
      m_vs = 1'b1;

      // Reset mid-line with Fireboy's box under the beam.
      Reset = 1'b1; vsync = 1'b1; blank = 1'b1;
      fb_x = 10'd100; fb_y = 10'd50; wg_x = 10'd600; wg_y = 10'd400;
      fb_left = 1'b0; wg_left = 1'b0; fb_moving = 1'b0; wg_moving = 1'b0;
      DrawX = 10'd105; DrawY = 10'd52;
      for (int i = 0; i < 3; i++) begin
         run_cycle();
         chk("rst_fb_hit", 32'(fb_hit), 32'd0);
         chk("rst_fb_addr", 32'(fb_rom_addr), 32'd0);
      end
      Reset = 1'b0;
      run_cycle();
      chk("addr69", 32'(fb_rom_addr), 32'd69);
      run_cycle();
      chk("hit_flushed", 32'(fb_hit), 32'd0);
      run_cycle();
      chk("first_hit", 32'(fb_hit), 32'd1);
      chk("first_index", 32'(index), 32'd9);

      fb_left = 1'b1;
      run_cycle();
      chk("addr90_mirror", 32'(fb_rom_addr), 32'd90);
      run_cycle();
      run_cycle();
      chk("transp_hit", 32'(fb_hit), 32'd0);
      chk("transp_index", 32'(index), 32'd0);

      fb_left = 1'b0; DrawX = 10'd132;
      run_cycle();
      chk("right_edge_addr", 32'(fb_rom_addr), 32'd0);
      DrawX = 10'd131;
      run_cycle();
      chk("last_col_addr", 32'(fb_rom_addr), 32'd95);
      DrawX = 10'd105; blank = 1'b0;
      run_cycle();
      chk("blank0_addr", 32'(fb_rom_addr), 32'd0);
      run_cycle();
      run_cycle();
      chk("blank0_hit", 32'(fb_hit), 32'd0);
      blank = 1'b1;

      // Watergirl near the right edge of the 10-bit column space.
      wg_x = 10'd1010; wg_y = 10'd200; DrawX = 10'd1015; DrawY = 10'd210;
      run_cycle();
      chk("wg_edge_addr", 32'(wg_rom_addr), 32'd325);
      run_cycle();
      run_cycle();
      chk("wg_edge_hit", 32'(wg_hit), 32'd1);
      chk("wg_edge_index2", 32'(index2), 32'd17);
      DrawX = 10'd5;
      run_cycle();
      chk("wg_nowrap_addr", 32'(wg_rom_addr), 32'd0);

      // Overlapping boxes: both characters report their own pixel.
      fb_x = 10'd300; fb_y = 10'd300; wg_x = 10'd310; wg_y = 10'd305;
      DrawX = 10'd315; DrawY = 10'd310;
      run_cycle();
      chk("ovl_fb_addr", 32'(fb_rom_addr), 32'd335);
      chk("ovl_wg_addr", 32'(wg_rom_addr), 32'd165);
      run_cycle();
      run_cycle();
      chk("ovl_fb_hit", 32'(fb_hit), 32'd1);
      chk("ovl_wg_hit", 32'(wg_hit), 32'd1);
      chk("ovl_index", 32'(index), 32'd12);
      chk("ovl_index2", 32'(index2), 32'd21);

      // Walk cycle over 40 ticks.
      fb_x = 10'd100; fb_y = 10'd50; DrawX = 10'd105; DrawY = 10'd52;
      fb_moving = 1'b1;
      k = 0;
      for (int n = 1; n <= 40; n++) begin
         tick_pulse();
         if (k < 5 && n == tick_at[k]) begin
            chk("walk_frame", 32'(fb_rom_addr), 32'(exp_frame[k] * SPR_W * SPR_H + 69));
            k++;
         end
      end
      fb_moving = 1'b0;
      run_cycle();
      chk("stop_no_tick", 32'(fb_rom_addr), 32'(2 * SPR_W * SPR_H + 69));
      tick_pulse();
      chk("stop_idle", 32'(fb_rom_addr), 32'd69);

      // Randomized traffic around both sprites.
      for (int i = 0; i < 3000; i++) begin
         Reset = ($urandom % 200 == 0);
         vsync = ($urandom % 6 != 0);
         blank = ($urandom % 8 != 0);
         if ($urandom % 20 == 0) fb_moving = ~fb_moving;
         if ($urandom % 20 == 0) wg_moving = ~wg_moving;
         if ($urandom % 16 == 0) fb_left = ~fb_left;
         if ($urandom % 16 == 0) wg_left = ~wg_left;
         if ($urandom % 50 == 0) begin
            fb_x = 10'($urandom); fb_y = 10'($urandom);
            wg_x = 10'($urandom); wg_y = 10'($urandom);
         end
         if ($urandom % 2 == 0) begin
            base = int'(fb_x); DrawX = 10'(base + int'($urandom_range(0, 40)) - 4);
            base = int'(fb_y); DrawY = 10'(base + int'($urandom_range(0, 40)) - 4);
         end else begin
            base = int'(wg_x); DrawX = 10'(base + int'($urandom_range(0, 40)) - 4);
            base = int'(wg_y); DrawY = 10'(base + int'($urandom_range(0, 40)) - 4);
         end
         run_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
